isocm_bram_port_ctrl: RTL and testbench



---
 rtl/isocm_bram_port_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_isocm_bram_port_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/isocm_bram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : isocm_bram_port_ctrl
// Purpose  : Drives one port of the 64-bit, two-lane ISOCM BRAM from a 32-bit
//            word-oriented request/response master. Single-beat writes and
//            incrementing read bursts of 1-16 words. The one-cycle BRAM read
//            latency is absorbed, and each read word is held until accepted.
// Revision : 1.0 - initial release
// ============================================================================
module isocm_bram_port_ctrl #(
  parameter int C_MEMSIZE     = 'h4000,
  parameter int C_PORT_DWIDTH = 64,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 2
) (
  input  logic                       BRAM_Clk,
  input  logic                       BRAM_Rst_N,
  // request channel
  input  logic                       Req_Valid,
  output logic                       Req_Ready,
  input  logic                       Req_Write,
  input  logic [0:31]                Req_Addr,
  input  logic [0:3]                 Req_Len,
  input  logic [0:31]                Req_WData,
  // response channel
  output logic                       Rsp_Valid,
  input  logic                       Rsp_Ready,
  output logic [0:31]                Rsp_RData,
  output logic                       Rsp_Last,
  // BRAM port
  output logic                       BRAM_EN,
  output logic [0:C_NUM_WE-1]        BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1]   BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1]   BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1]   BRAM_Din,
  output logic                       BRAM_Rst
);

  // Word-index bits that take part in the burst increment; everything above
  // them is held, so a burst wraps within the memory size.
  localparam logic [0:29] C_WRAP_MASK = 30'(C_MEMSIZE / 4 - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    RD_RESP    = 3'd3,
    WR         = 3'd4,
    WR_RESP    = 3'd5
  } state_e;

  state_e       state_q, state_d;
  logic [0:29]  addr_q, addr_d;      // word address of the current beat
  logic         write_q, write_d;    // current transaction is a write
  logic [0:31]  wdata_q, wdata_d;    // write word, replicated onto both lanes
  logic [0:3]   cnt_q, cnt_d;        // read beats remaining after this one
  logic [0:31]  rdata_q, rdata_d;    // captured read word
  logic         last_q, last_d;      // captured read word is the final beat

  logic         idle;
  logic         bram_en;
  logic [0:1]   bram_wen;
  logic         rsp_valid;
  logic [0:29]  addr_inc;

  // Byte-offset bits inside a word are not meaningful for a word master.
  logic         unused_addr_lsbs;
  assign unused_addr_lsbs = ^Req_Addr[30:31];

  // Next word address of a burst: low index bits count, upper bits hold.
  assign addr_inc = (addr_q & ~C_WRAP_MASK) | ((addr_q + 30'd1) & C_WRAP_MASK);

  // Next-state, datapath next-values and state-decoded strobes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    last_d    = last_q;
    idle      = 1'b0;
    bram_en   = 1'b0;
    bram_wen  = 2'b00;
    rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        idle = 1'b1;
        if (Req_Valid) begin
          addr_d  = Req_Addr[0:29];
          write_d = Req_Write;
          wdata_d = Req_WData;
          // Writes are always single-beat regardless of the length field.
          cnt_d   = Req_Write ? 4'd0 : Req_Len;
          state_d = Req_Write ? WR : RD_ISSUE;
        end
      end

      RD_ISSUE: begin
        bram_en = 1'b1;
        state_d = RD_CAPTURE;
      end

      RD_CAPTURE: begin
        // BRAM output is valid one cycle after the enable; pick the lane
        // that holds the addressed word.
        rdata_d = addr_q[29] ? BRAM_Din[32:63] : BRAM_Din[0:31];
        last_d  = (cnt_q == 4'd0);
        state_d = RD_RESP;
      end

      RD_RESP: begin
        rsp_valid = 1'b1;
        if (Rsp_Ready) begin
          if (cnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            addr_d  = addr_inc;
            state_d = RD_ISSUE;
          end
        end
      end

      WR: begin
        bram_en  = 1'b1;
        bram_wen = addr_q[29] ? 2'b01 : 2'b10;
        state_d  = WR_RESP;
      end

      WR_RESP: begin
        rsp_valid = 1'b1;
        if (Rsp_Ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction at once.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end

  // Ready is gated by the reset pin so it is low for the whole reset window.
  assign Req_Ready = idle & BRAM_Rst_N;

  // Write acknowledges return zero data and always close the transaction.
  assign Rsp_Valid = rsp_valid;
  assign Rsp_RData = write_q ? 32'd0 : rdata_q;
  assign Rsp_Last  = write_q | last_q;

  // Enables come from the state register only, so reset removes them with
  // no combinational path from the request inputs.
  assign BRAM_EN   = bram_en;
  assign BRAM_WEN  = C_NUM_WE'(bram_wen);
  assign BRAM_Addr = C_PORT_AWIDTH'({addr_q[0:28], 3'b000});
  assign BRAM_Dout = C_PORT_DWIDTH'({wdata_q, wdata_q});
  assign BRAM_Rst  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_isocm_bram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_isocm_bram_port_ctrl
// Purpose  : Self-checking bench for isocm_bram_port_ctrl with a BRAM model
//            and a word-array reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isocm_bram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_len;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_rdata;
  logic        bram_en, bram_rst;
  logic [1:0]  bram_wen;
  logic [31:0] bram_addr;
  logic [63:0] bram_dout;
  logic [63:0] bram_din = 64'd0;

  // BRAM model storage and its preload port
  logic [63:0] bram_mem [0:2047];
  logic        pl_en;
  logic [10:0] pl_idx;
  logic [63:0] pl_val;

  // Reference memory: one entry per 32-bit word of the 16 KB space
  logic [31:0] ref_mem [0:4095];

  int n_checks = 0;
  int n_errors = 0;

  isocm_bram_port_ctrl dut (
    .BRAM_Clk   (clk),
    .BRAM_Rst_N (rst_n),
    .Req_Valid  (req_valid),
    .Req_Ready  (req_ready),
    .Req_Write  (req_write),
    .Req_Addr   (req_addr),
    .Req_Len    (req_len),
    .Req_WData  (req_wdata),
    .Rsp_Valid  (rsp_valid),
    .Rsp_Ready  (rsp_ready),
    .Rsp_RData  (rsp_rdata),
    .Rsp_Last   (rsp_last),
    .BRAM_EN    (bram_en),
    .BRAM_WEN   (bram_wen),
    .BRAM_Addr  (bram_addr),
    .BRAM_Dout  (bram_dout),
    .BRAM_Din   (bram_din),
    .BRAM_Rst   (bram_rst)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM: upper lane = wen[1], one-cycle read latency
  always @(posedge clk) begin
    if (pl_en) begin
      bram_mem[pl_idx] <= pl_val;
    end else if (bram_en) begin
      if (bram_wen[1]) bram_mem[bram_addr[13:3]][63:32] <= bram_dout[63:32];
      if (bram_wen[0]) bram_mem[bram_addr[13:3]][31:0]  <= bram_dout[31:0];
      bram_din <= bram_mem[bram_addr[13:3]];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] widx(input logic [31:0] addr, input int beat);
    return 12'(((addr >> 2) + 32'(beat)) % 4096);
  endfunction

  task automatic preload(input logic [31:0] byte_addr, input logic [63:0] val);
    logic [11:0] w;
    w = widx(byte_addr & ~32'h7, 0);
    ref_mem[w]         = val[63:32];
    ref_mem[w + 12'd1] = val[31:0];
    pl_en  = 1'b1;
    pl_idx = byte_addr[13:3];
    pl_val = val;
    step();
    pl_en  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_bram_en"},   64'(bram_en),   64'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int stall);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
    req_len   = 4'($urandom_range(0, 15)); req_wdata = data;
    chk("wr_req_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    chk("wr_en",        64'(bram_en),   64'd1);
    chk("wr_wen",       64'(bram_wen),  64'(addr[2] ? 2'b01 : 2'b10));
    chk("wr_addr",      64'(bram_addr), 64'(addr & ~32'h7));
    chk("wr_dout",      bram_dout,      {data, data});
    chk("wr_rsp_early", 64'(rsp_valid), 64'd0);
    ref_mem[widx(addr, 0)] = data;
    step();
    for (int s = 0; s <= stall; s++) begin
      chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("wr_rsp_last",  64'(rsp_last),  64'd1);
      chk("wr_rsp_en",    64'(bram_en),   64'd0);
      chk("wr_rsp_busy",  64'(req_ready), 64'd0);
      if (s < stall) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_idle("wr_done");
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int stall_beat,
                         input int stall_cycles, input bit rnd_stall, input bit hold_req,
                         input int abort_beat);
    logic [11:0] w;
    logic [31:0] exp_byte;
    int          st;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    req_len   = 4'(len); req_wdata = $urandom;
    chk("rd_req_ready", 64'(req_ready), 64'd1);
    step();
    if (!hold_req) req_valid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      w        = widx(addr, b);
      exp_byte = (addr & 32'hFFFF_C000) | (32'(w) << 2);
      chk("rd_issue_en",   64'(bram_en),   64'd1);
      chk("rd_issue_wen",  64'(bram_wen),  64'd0);
      chk("rd_issue_addr", 64'(bram_addr), 64'(exp_byte & ~32'h7));
      chk("rd_busy_ready", 64'(req_ready), 64'd0);
      if (b == abort_beat) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_en",        64'(bram_en),   64'd0);
        chk("abort_wen",       64'(bram_wen),  64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        chk("abort_rdata",     64'(rsp_rdata), 64'd0);
        chk("abort_last",      64'(rsp_last),  64'd0);
        chk("abort_addr",      64'(bram_addr), 64'd0);
        step();
        step();
        #3 rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
          check_idle("abort_after");
          step();
        end
        return;
      end
      step();
      chk("rd_cap_en",    64'(bram_en),   64'd0);
      chk("rd_cap_valid", 64'(rsp_valid), 64'd0);
      step();
      st = rnd_stall ? int'($urandom_range(0, 3)) : ((b == stall_beat) ? stall_cycles : 0);
      for (int s = 0; s <= st; s++) begin
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'(ref_mem[w]));
        chk("rd_rsp_last",  64'(rsp_last),  64'(b == len));
        chk("rd_rsp_en",    64'(bram_en),   64'd0);
        chk("rd_rsp_busy",  64'(req_ready), 64'd0);
        if (s < st) step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    chk("rd_done_ready", 64'(req_ready), 64'd1);
    chk("rd_done_valid", 64'(rsp_valid), 64'd0);
    if (!hold_req) begin
      step();
      check_idle("rd_done_idle");
    end
  endtask

  initial begin
    logic [31:0] a, hi, lo;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_len = '0; req_wdata = '0; rsp_ready = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_last",  64'(rsp_last),  64'd0);
    chk("rst_bram_en",   64'(bram_en),   64'd0);
    chk("rst_bram_wen",  64'(bram_wen),  64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    chk("rst_bram_dout", bram_dout,      64'd0);
    chk("rst_bram_rst",  64'(bram_rst),  64'd0);

    // Fill BRAM and reference with random contents while held in reset
    for (int d = 0; d < 2048; d++) begin
      hi = $urandom; lo = $urandom;
      ref_mem[12'(2 * d)]     = hi;
      ref_mem[12'(2 * d + 1)] = lo;
      pl_en = 1'b1; pl_idx = 11'(d); pl_val = {hi, lo};
      step();
    end
    pl_en = 1'b0;
    chk("rst_hold_ready", 64'(req_ready), 64'd0);
    #3 rst_n = 1'b1;
    step();
    check_idle("post_rst");

    // Single write to the odd word of a doubleword
    do_write(32'h0000_0104, 32'hDEAD_BEEF, 0);

    // Preloaded doubleword read back as two single-beat reads
    preload(32'h0000_0100, 64'h1122_3344_5566_7788);
    do_read(32'h0000_0100, 0, -1, 0, 1'b0, 1'b0, -1);
    do_read(32'h0000_0104, 0, -1, 0, 1'b0, 1'b0, -1);

    // Burst wrapping at the top of memory, then with a 5-cycle stall on beat 2
    do_read(32'h0000_3FF8, 3, -1, 0, 1'b0, 1'b0, -1);
    do_read(32'h0000_3FF8, 3, 1, 5, 1'b0, 1'b0, -1);

    // Request held valid across a 2-beat read, then accepted once
    do_read(32'h0000_0200, 1, -1, 0, 1'b0, 1'b1, -1);
    do_read(32'h0000_0200, 1, -1, 0, 1'b0, 1'b0, -1);

    // Randomized mix of writes and reads
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = (a & 32'hFFFF_C000) | 32'h3FC0 | (a & 32'h3C);
      a = a & ~32'h3;
      if ($urandom_range(0, 2) == 0)
        do_write(a, $urandom, int'($urandom_range(0, 2)));
      else
        do_read(a, int'($urandom_range(0, 15)), -1, 0, 1'b1, 1'b0, -1);
    end

    // Reset in the middle of an 8-beat burst
    do_read(32'h0000_1000, 7, -1, 0, 1'b0, 1'b0, 3);

    // Normal operation after the abort
    do_write(32'h0000_1008, 32'hCAFE_F00D, 1);
    do_read(32'h0000_1008, 0, -1, 0, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
